spi_rom_responder: RTL
======================

SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning the byte-address width of the internal memory (2^MEM_AW bytes).
REQ-002 SHALL have parameter DUMMY_CYCLES, default 8, meaning the number of SCLK cycles between ADDR[0] and the first data bit for FAST READ (0Bh).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_cs, input, 1 bit: chip select, active HIGH.
REQ-006 SHALL have port spi_sclk, input, 1 bit: SPI clock, mode 0, idle low.
REQ-007 SHALL have port spi_mosi, input, 1 bit: command, address and dummy bits, MSB first.
REQ-008 SHALL have port spi_miso, output, 1 bit: registered read data, MSB first.
REQ-009 SHALL have port wr_en, input, 1 bit: host write strobe for the memory load port.
REQ-010 SHALL have port wr_addr, input, MEM_AW bits: host write byte address.
REQ-011 SHALL have port wr_data, input, 8 bits: host write byte.
REQ-012 SHALL have port active, output, 1 bit: high while the state is CMD, ADDR, DUMMY or DATA.
REQ-013 SHALL have port cmd_error, output, 1 bit: one-clk pulse when a completed command byte is unsupported.

Function
REQ-014 SHALL pass spi_cs, spi_sclk and spi_mosi through 2-FF synchronizers, then detect SCLK rise and fall from the synchronized value.
REQ-015 SHALL operate correctly when clk is at least 4x SCLK and SCLK high and low phases each last at least 2 clk periods; behaviour outside this range is undefined.
REQ-016 SHALL sample MOSI on the detected SCLK rise and update MISO on the detected SCLK fall.
REQ-017 SHALL use states IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-018 SHALL go IDLE->CMD on synchronized CS rise, clearing the bit counter.
REQ-019 SHALL go CMD->ADDR after 8 bits when the opcode is 03h or 0Bh; for any other opcode it SHALL go CMD->IGNORE and pulse cmd_error.
REQ-020 SHALL go ADDR->DATA after 24 bits for 03h, and ADDR->DUMMY for 0Bh.
REQ-021 SHALL go DUMMY->DATA after DUMMY_CYCLES rises; MOSI is ignored during DUMMY.
REQ-022 SHALL use only the low MEM_AW bits of the 24-bit address; upper bits are ignored.
REQ-023 SHALL read the addressed byte, registered with one-clk latency, on the rise that samples ADDR[0] (03h) or the last dummy bit (0Bh), and drive its bit 7 on the following fall.
REQ-024 SHALL shift out bits 6..0 on subsequent falls, then continue with the next byte.
REQ-025 SHALL increment the address at each byte boundary, wrapping modulo 2^MEM_AW.
REQ-026 SHALL prefetch the next byte during the current byte so there is no gap between bytes.
REQ-027 SHALL hold MISO at 0 in IDLE, CMD, ADDR, DUMMY and IGNORE.
REQ-028 SHALL, on synchronized CS fall in any state, go to IDLE within 1 clk, set MISO to 0 and clear the counters; a new CS rise SHALL restart at CMD.
REQ-029 SHALL stay in IGNORE until CS falls.
REQ-030 SHALL write memory on every clk with wr_en high, in any state.
REQ-031 SHALL, when a read and a write hit the same address in the same clk, return the old data (read-before-write).

Reset
REQ-032 SHALL, while reset_n is low, set state to IDLE, spi_miso to 0, active to 0, cmd_error to 0, and clear all counters, the shift register and the synchronizers.
REQ-033 SHALL leave memory contents unchanged through reset.
REQ-034 SHALL, when reset_n is deasserted while CS is high, wait for a fresh CS rise before responding.

Structure
REQ-035 SHALL take opcode constants (03h, 0Bh) and state encodings from a shared SPI defines header included alongside the existing helpers.
REQ-036 SHALL implement synchronization and edge detection in one sub-module, spi_sync_edge, instantiated once per input.

Verification
REQ-037 SHALL cover: mem[10h]=A5h and mem[11h]=3Ch, CS, 03h 000010h, 16 SCLK -> MISO A5h then 3Ch.
REQ-038 SHALL cover: mem[FFh]=11h and mem[00h]=22h, read at 0000FFh -> 11h then 22h (wrap); read at 123410h -> mem[10h].
REQ-039 SHALL cover: 0Bh 000010h plus 8 dummy clocks -> MISO A5h; MISO is 0 throughout the dummy phase.
REQ-040 SHALL cover: opcode 9Fh -> cmd_error high for exactly 1 clk, MISO stays 0 for 32 further clocks, active low.
REQ-041 SHALL cover: CS dropped after 12 address bits, then a fresh 03h 000011h -> 3Ch.
REQ-042 SHALL cover: reset_n pulsed low mid-DATA -> MISO 0 immediately; memory is intact on the next read.

Source files
------------

// File: rtl/spi_rom_responder_pkg.sv
// Shared SPI definitions for the ROM responder: opcodes, FSM state encoding and opcode helper.
package spi_rom_responder_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam int         ADDR_BITS    = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } spi_state_e;

    function automatic logic is_read_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_FAST_READ);
    endfunction

endpackage

// File: rtl/spi_rom_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI mode-0 ROM slave answering READ (03h) and FAST READ (0Bh) from an internal
// byte memory that the host loads through a simple write port.
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int MEM_AW       = 8,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              active,
    output logic              cmd_error
);

    localparam int CNT_MAX = (DUMMY_CYCLES > ADDR_BITS) ? DUMMY_CYCLES : ADDR_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [2:0] s_lvl, s_rise, s_fall;

    // Index 2 = CS, 1 = SCLK, 0 = MOSI; all three see identical latency.
    spi_sync_edge u_sync [2:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     ({spi_cs, spi_sclk, spi_mosi}),
        .level_o (s_lvl),
        .rise_o  (s_rise),
        .fall_o  (s_fall)
    );

    logic cs_lvl, cs_rise, sclk_rise, sclk_fall, mosi_lvl;
    logic sync_unused;
    assign cs_lvl      = s_lvl[2];
    assign cs_rise     = s_rise[2];
    assign sclk_rise   = s_rise[1];
    assign sclk_fall   = s_fall[1];
    assign mosi_lvl    = s_lvl[0];
    assign sync_unused = ^{s_fall[2], s_lvl[1], s_rise[0], s_fall[0]};

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        cmd_sr_q, cmd_sr_d;
    logic [MEM_AW-1:0] addr_q, addr_d, addr_nxt;
    logic [6:0]        data_sr_q, data_sr_d;
    logic [2:0]        dbit_q, dbit_d;
    logic              fast_q, fast_d;
    logic              miso_q, miso_d;
    logic              err_q, err_d;
    logic [1:0]        settle_q;
    logic              armed_q;
    logic [7:0]        opcode;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_addr;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

    // Memory has no reset so contents survive reset; reads return pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        addr_d    = addr_q;
        data_sr_d = data_sr_q;
        dbit_d    = dbit_q;
        fast_d    = fast_q;
        miso_d    = miso_q;
        err_d     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = addr_q;
        opcode    = {cmd_sr_q, mosi_lvl};
        addr_nxt  = (addr_q << 1) | MEM_AW'(mosi_lvl);

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                dbit_d = '0;
                if (cs_rise && armed_q) state_d = ST_CMD;
            end
            ST_CMD: if (sclk_rise) begin
                cmd_sr_d = opcode[6:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d = '0;
                    if (is_read_op(opcode)) begin
                        state_d = ST_ADDR;
                        fast_d  = (opcode == OP_FAST_READ);
                    end else begin
                        state_d = ST_IGNORE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: if (sclk_rise) begin
                addr_d = addr_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                    cnt_d   = '0;
                    rd_en   = 1'b1;
                    rd_addr = addr_nxt;
                    state_d = (fast_q && DUMMY_CYCLES != 0) ? ST_DUMMY : ST_DATA;
                end
            end
            ST_DUMMY: if (sclk_rise) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                    cnt_d   = '0;
                    rd_en   = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (sclk_fall) begin
                dbit_d = dbit_q + 1'b1;
                if (dbit_q == 3'd0) begin
                    // Byte boundary: present the fetched byte, prefetch the next one.
                    miso_d    = rd_data_q[7];
                    data_sr_d = rd_data_q[6:0];
                    addr_d    = addr_q + 1'b1;
                    rd_en     = 1'b1;
                    rd_addr   = addr_q + 1'b1;
                end else begin
                    miso_d    = data_sr_q[6];
                    data_sr_d = {data_sr_q[5:0], 1'b0};
                end
            end
            ST_IGNORE: ;
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !cs_lvl) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            cnt_d   = '0;
            dbit_d  = '0;
            err_d   = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_sr_q  <= '0;
            addr_q    <= '0;
            data_sr_q <= '0;
            dbit_q    <= '0;
            fast_q    <= 1'b0;
            miso_q    <= 1'b0;
            err_q     <= 1'b0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            addr_q    <= addr_d;
            data_sr_q <= data_sr_d;
            dbit_q    <= dbit_d;
            fast_q    <= fast_d;
            miso_q    <= miso_d;
            err_q     <= err_d;
            // Only accept a CS rise once CS has been seen low after the synchronizers settle.
            settle_q  <= (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
            armed_q   <= armed_q | ((settle_q == 2'd3) & ~cs_lvl);
        end
    end

    assign spi_miso  = miso_q;
    assign cmd_error = err_q;
    assign active    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                       (state_q == ST_DUMMY) || (state_q == ST_DATA);

endmodule
